// File: rtl/mux_rr_arbiter.sv
// Round-robin arbiter that feeds one registered byte-select output from NumReq requesters.
// Optional burst lock (lock_i) is built in when MUX_RR_ARBITER_LOCK_EN is defined.

module mux_rr_arbiter #(
    parameter int Width  = 8,
    parameter int NumReq = 8,
    localparam int SelW  = $clog2(NumReq)
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic [NumReq-1:0]       req_i,
    input  logic [NumReq*Width-1:0] data_i,
`ifdef MUX_RR_ARBITER_LOCK_EN
    input  logic [NumReq-1:0]       lock_i,
`endif
    output logic [NumReq-1:0]       gnt_o,
    output logic [SelW-1:0]         sel_o,
    output logic                    out_valid_o,
    output logic [Width-1:0]        out_data_o,
    input  logic                    out_ready_i
);

    typedef enum logic {
        IDLE = 1'b0,
        FULL = 1'b1
    } state_e;

    typedef struct packed {
        logic            found;
        logic [SelW-1:0] idx;
    } pick_t;

    // First requesting index at or after start, wrapping modulo NumReq.
    // NumReq is a power of two, so SelW-bit addition wraps for free.
    function automatic pick_t pick_winner(input logic [NumReq-1:0] req,
                                          input logic [SelW-1:0]   start);
        pick_t           p;
        logic [SelW-1:0] idx;
        p = '0;
        for (int i = 0; i < NumReq; i++) begin
            idx = start + SelW'(i);
            if (!p.found && req[idx]) begin
                p.found = 1'b1;
                p.idx   = idx;
            end
        end
        return p;
    endfunction

    state_e           state_q, state_d;
    logic [SelW-1:0]  ptr_q,   ptr_d;
    logic [SelW-1:0]  sel_q,   sel_d;
    logic [Width-1:0] data_q,  data_d;
    logic             valid_q, valid_d;

    pick_t            pick;
    logic             cap;
    logic             grant;

    always_comb begin
        pick  = pick_winner(req_i, ptr_q);
        cap   = (state_q == IDLE) || out_ready_i;
        // No grant while reset is asserted, so no requester believes its word was taken.
        grant = rst_i && cap && pick.found;
        gnt_o = grant ? (NumReq'(1) << pick.idx) : '0;
    end

    always_comb begin
        // NOTE: every variable gets a default first so no path leaves it unassigned,
        // which would otherwise infer a latch.
        state_d = state_q;
        ptr_d   = ptr_q;
        sel_d   = sel_q;
        data_d  = data_q;
        valid_d = valid_q;

        if (grant) begin
            state_d = FULL;
            valid_d = 1'b1;
            sel_d   = pick.idx;
            data_d  = data_i[pick.idx*Width +: Width];
`ifdef MUX_RR_ARBITER_LOCK_EN
            ptr_d   = lock_i[pick.idx] ? pick.idx : pick.idx + SelW'(1);
`else
            ptr_d   = pick.idx + SelW'(1);
`endif
        end else if (state_q == FULL && out_ready_i) begin
            // Consumer took the word and nobody is asking: go empty, keep last data/sel.
            state_d = IDLE;
            valid_d = 1'b0;
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so every flop
    // samples the pre-edge value of every other flop.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            sel_q   <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            sel_q   <= sel_d;
            data_q  <= data_d;
            valid_q <= valid_d;
        end
    end

    assign sel_o       = sel_q;
    assign out_data_o  = data_q;
    assign out_valid_o = valid_q;

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// Self-checking bench for mux_rr_arbiter: vector table, hand-written sequences, word scoreboard.
// Lock sequence runs only when MUX_RR_ARBITER_LOCK_EN is defined.

module tb_mux_rr_arbiter;

    localparam int W = 8;
    localparam int N = 8;

    logic           clk_i = 1'b0;
    logic           rst_i;
    logic [N-1:0]   req_i;
    logic [N*W-1:0] data_i;
    logic           out_ready_i;
    logic [N-1:0]   gnt_o;
    logic [2:0]     sel_o;
    logic           out_valid_o;
    logic [W-1:0]   out_data_o;
`ifdef MUX_RR_ARBITER_LOCK_EN
    logic [N-1:0]   lock_i;
`endif

    always #5 clk_i = ~clk_i;

    mux_rr_arbiter #(.Width(W), .NumReq(N)) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .req_i       (req_i),
        .data_i      (data_i),
`ifdef MUX_RR_ARBITER_LOCK_EN
        .lock_i      (lock_i),
`endif
        .gnt_o       (gnt_o),
        .sel_o       (sel_o),
        .out_valid_o (out_valid_o),
        .out_data_o  (out_data_o),
        .out_ready_i (out_ready_i)
    );

    typedef struct {
        logic         rst;
        logic [7:0]   req;
        logic [7:0]   lock;
        logic [63:0]  data;
        logic         rdy;
        logic [7:0]   exp_gnt;
        logic         exp_valid;
        logic [2:0]   exp_sel;
        logic [7:0]   exp_out;
    } vec_t;

    typedef struct {
        logic [2:0] sel;
        logic [7:0] data;
    } word_t;

    int    total = 0;
    int    bad   = 0;
    word_t sb_q[$];
    vec_t  vecs[23];

    localparam logic [63:0] D_SEQ = 64'h3736_3534_3332_3130;
    localparam logic [63:0] D_A5  = 64'h0000_00A5_0000_0000;
    localparam logic [63:0] D_5A  = 64'h0000_0000_00C3_005A;
    localparam logic [63:0] D_66  = 64'h0066_0000_0000_0000;
    localparam logic [63:0] D_12  = 64'h0000_0000_0022_0011;
    localparam logic [63:0] D_LK  = 64'h0000_0000_00B2_B100;

    function automatic vec_t mk(input logic rst, input logic [7:0] req, input logic [63:0] data,
                                input logic rdy, input logic [7:0] gnt, input logic valid,
                                input logic [2:0] sel, input logic [7:0] out);
        vec_t v;
        v.rst = rst; v.req = req; v.lock = 8'h00; v.data = data; v.rdy = rdy;
        v.exp_gnt = gnt; v.exp_valid = valid; v.exp_sel = sel; v.exp_out = out;
        return v;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h want=%0h", name, act, exp);
        end
    endtask

    // One clock: drive at negedge, check grant and scoreboard before the edge, registers after.
    task automatic step(input vec_t v, input string tag);
        word_t w;
        @(negedge clk_i);
        rst_i       = v.rst;
        req_i       = v.req;
        data_i      = v.data;
        out_ready_i = v.rdy;
`ifdef MUX_RR_ARBITER_LOCK_EN
        lock_i      = v.lock;
`endif
        #1;
        check({tag, ".gnt"}, 64'(gnt_o), 64'(v.exp_gnt));
        if (!v.rst) begin
            sb_q.delete();
        end else begin
            if (out_valid_o === 1'b1 && v.rdy) begin
                check({tag, ".sb_nonempty"}, 64'(sb_q.size() > 0), 64'd1);
                if (sb_q.size() > 0) begin
                    w = sb_q.pop_front();
                    check({tag, ".sb_sel"},  64'(sel_o),      64'(w.sel));
                    check({tag, ".sb_data"}, 64'(out_data_o), 64'(w.data));
                end
            end
            for (int k = 0; k < N; k++) begin
                if (v.exp_gnt[k]) begin
                    w.sel  = 3'(k);
                    w.data = v.data[k*W +: W];
                    sb_q.push_back(w);
                end
            end
        end
        @(posedge clk_i);
        #1;
        check({tag, ".valid"}, 64'(out_valid_o), 64'(v.exp_valid));
        check({tag, ".sel"},   64'(sel_o),       64'(v.exp_sel));
        check({tag, ".data"},  64'(out_data_o),  64'(v.exp_out));
    endtask

    initial begin
        vec_t v;
        rst_i = 1'b0; req_i = '0; data_i = '0; out_ready_i = 1'b0;
`ifdef MUX_RR_ARBITER_LOCK_EN
        lock_i = '0;
`endif
        //              rst req    data   rdy gnt    vld sel  out
        vecs[0]  = mk(0, 8'hFF, D_SEQ, 1, 8'h00, 0, 3'd0, 8'h00); // reset, requests ignored
        vecs[1]  = mk(0, 8'hFF, D_SEQ, 1, 8'h00, 0, 3'd0, 8'h00);
        vecs[2]  = mk(1, 8'hFF, D_SEQ, 0, 8'h01, 1, 3'd0, 8'h30); // first grant to 0
        vecs[3]  = mk(1, 8'h00, D_SEQ, 1, 8'h00, 0, 3'd0, 8'h30); // drain
        vecs[4]  = mk(1, 8'h10, D_A5,  1, 8'h10, 1, 3'd4, 8'hA5); // single request
        vecs[5]  = mk(1, 8'h00, D_A5,  1, 8'h00, 0, 3'd4, 8'hA5);
        vecs[6]  = mk(1, 8'h01, D_5A,  1, 8'h01, 1, 3'd0, 8'h5A); // ptr 5 wraps to 0
        vecs[7]  = mk(1, 8'h04, D_5A,  0, 8'h00, 1, 3'd0, 8'h5A); // backpressure x3
        vecs[8]  = mk(1, 8'h04, D_5A,  0, 8'h00, 1, 3'd0, 8'h5A);
        vecs[9]  = mk(1, 8'h04, D_5A,  0, 8'h00, 1, 3'd0, 8'h5A);
        vecs[10] = mk(1, 8'h04, D_5A,  1, 8'h04, 1, 3'd2, 8'hC3); // accept + capture same edge
        vecs[11] = mk(1, 8'h40, D_66,  1, 8'h40, 1, 3'd6, 8'h66); // ptr -> 7
        vecs[12] = mk(1, 8'h05, D_12,  1, 8'h01, 1, 3'd0, 8'h11); // wrap 7 -> 0
        vecs[13] = mk(1, 8'h05, D_12,  1, 8'h04, 1, 3'd2, 8'h22); // skip 1 -> 2
        vecs[14] = mk(1, 8'h00, D_12,  1, 8'h00, 0, 3'd2, 8'h22); // drain
        vecs[15] = mk(1, 8'h00, D_12,  1, 8'h00, 0, 3'd2, 8'h22); // idle stays idle
        vecs[16] = mk(1, 8'h02, D_SEQ, 0, 8'h02, 1, 3'd1, 8'h31); // IDLE grants without ready
        vecs[17] = mk(1, 8'h88, D_SEQ, 0, 8'h00, 1, 3'd1, 8'h31); // stall, ptr held at 2
        vecs[18] = mk(1, 8'h80, D_SEQ, 1, 8'h80, 1, 3'd7, 8'h37); // 3 dropped, 7 wins
        vecs[19] = mk(1, 8'h00, D_SEQ, 1, 8'h00, 0, 3'd7, 8'h37);
        vecs[20] = mk(1, 8'hFF, D_SEQ, 0, 8'h01, 1, 3'd0, 8'h30);
        vecs[21] = mk(0, 8'hFF, D_SEQ, 1, 8'h00, 0, 3'd0, 8'h00); // reset mid-transfer
        vecs[22] = mk(1, 8'hFF, D_SEQ, 1, 8'h01, 1, 3'd0, 8'h30); // ptr back at 0

        for (int i = 0; i < 23; i++) step(vecs[i], $sformatf("vec%0d", i));

        // Round-robin continues from ptr=1 with every requester asserted.
        for (int i = 0; i < 9; i++) begin
            int k;
            k = (i + 1) % N;
            v = mk(1, 8'hFF, D_SEQ, 1, 8'(1 << k), 1, 3'(k), 8'(8'h30 + k));
            step(v, $sformatf("rr%0d", i));
        end
        step(mk(1, 8'h00, D_SEQ, 1, 8'h00, 0, 3'd1, 8'h31), "rr_drain");

`ifdef MUX_RR_ARBITER_LOCK_EN
        step(mk(0, 8'h00, D_LK, 1, 8'h00, 0, 3'd0, 8'h00), "lk_rst");
        for (int i = 0; i < 4; i++) begin
            v = mk(1, 8'h06, D_LK, 1, 8'h02, 1, 3'd1, 8'hB1);
            v.lock = (i < 3) ? 8'h02 : 8'h00;
            step(v, $sformatf("lk%0d", i));
        end
        step(mk(1, 8'h06, D_LK, 1, 8'h04, 1, 3'd2, 8'hB2), "lk_next");
        step(mk(1, 8'h00, D_LK, 1, 8'h00, 0, 3'd2, 8'hB2), "lk_drain");
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
